// File: rtl/pulse_sync.sv
// Brings an asynchronous strobe into the sysClk domain and turns each rising edge
// into a single-cycle pulse, regardless of how long the strobe stays high.
module pulse_sync (
  input  logic sysClk,
  input  logic reset,
  input  logic sig_in,
  output logic pulse_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q,   dly_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  // Rising edge of the synchronised strobe
  assign pulse_c = sync2_q & ~dly_q;

endmodule

// File: rtl/rx_byte_buffer.sv
// Show-ahead receive FIFO between the UART receiver and the core's input path.
// Bytes are captured on each synchronised receive_done edge and held until popped.
module rx_byte_buffer #(
  parameter int unsigned addrSize_fifo = 4
) (
  input  logic                   sysClk,
  input  logic                   reset,
  input  logic [7:0]             data_rx,
  input  logic                   receive_done,
  input  logic                   rd_req,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  output logic                   empty,
  output logic                   full,
  output logic [addrSize_fifo:0] count,
  output logic                   overflow
);

  localparam int unsigned AW    = addrSize_fifo;
  localparam int unsigned CW    = addrSize_fifo + 1;
  localparam int unsigned DEPTH = 1 << addrSize_fifo;

  logic          wr_c;
  logic          push_c;
  logic          pop_c;
  logic          empty_c;
  logic          full_c;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;

  pulse_sync u_rx_sync (
    .sysClk  (sysClk),
    .reset   (reset),
    .sig_in  (receive_done),
    .pulse_c (wr_c)
  );

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a write while full still lands if popped
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    pop_c  = rd_req & ~empty_c;
    push_c = wr_c & (~full_c | pop_c);

    if (push_c) begin
      mem_d[wr_ptr_q] = data_rx;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_c && !push_c) begin
      overflow_d = 1'b1;
    end

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_out   = mem_q[rd_ptr_q];
  assign data_valid = ~empty_c;
  assign empty      = empty_c;
  assign full       = full_c;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rx_byte_buffer.sv
// Self-checking bench for rx_byte_buffer: vector table, hand-written corner sequences,
// and random push/pop traffic compared against a queue-based reference model.
module tb_rx_byte_buffer;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_rx;
  logic       receive_done;
  logic       rd_req;
  logic [7:0] data_out;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic       m_ov;

  typedef struct {
    int         op;        // 0 = push, 1 = pop
    logic [7:0] din;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[$];

  rx_byte_buffer #(.addrSize_fifo(4)) dut (
    .sysClk       (clk),
    .reset        (rst_n),
    .data_rx      (data_rx),
    .receive_done (receive_done),
    .rd_req       (rd_req),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, "_valid"}, 32'(data_valid), 32'(mq.size() != 0));
    chk({tag, "_full"},  32'(full), 32'(mq.size() == DEPTH));
    chk({tag, "_ovf"},   32'(overflow), 32'(m_ov));
    if (mq.size() > 0) chk({tag, "_head"}, 32'(data_out), 32'(mq[0]));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    receive_done = 1'b0;
    rd_req       = 1'b0;
    data_rx      = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    mq.delete();
    m_ov = 1'b0;
  endtask

  task automatic push_raw(input logic [7:0] d, input int w);
    data_rx      = d;
    receive_done = 1'b1;
    repeat (w) tick();
    receive_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop_raw();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // rd_req is placed in the one cycle where the synchronised write pulse is high
  task automatic push_pop_raw(input logic [7:0] d);
    data_rx      = d;
    receive_done = 1'b1;
    tick();
    tick();
    rd_req = 1'b1;
    tick();
    rd_req       = 1'b0;
    receive_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic m_push(input logic [7:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_ov = 1'b1;
  endtask

  task automatic m_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic m_push_pop(input logic [7:0] d);
    if (mq.size() > 0) void'(mq.pop_front());
    mq.push_back(d);
  endtask

  initial begin
    vec_t v;
    logic [7:0] b;
    int r;

    // Vector table: ordered bytes, empty pops, fill, overflow, drain
    vecs.push_back('{0, 8'h2B, 1, 8'h2B, 1'b0});
    vecs.push_back('{0, 8'h2D, 2, 8'h2B, 1'b0});
    vecs.push_back('{0, 8'h2E, 3, 8'h2B, 1'b0});
    vecs.push_back('{1, 8'h00, 2, 8'h2D, 1'b0});
    vecs.push_back('{1, 8'h00, 1, 8'h2E, 1'b0});
    vecs.push_back('{1, 8'h00, 0, 8'h00, 1'b0});
    vecs.push_back('{1, 8'h00, 0, 8'h00, 1'b0});
    for (int i = 0; i < 16; i++) vecs.push_back('{0, 8'(i), i + 1, 8'h00, 1'b0});
    vecs.push_back('{0, 8'hFF, 16, 8'h00, 1'b1});
    for (int i = 0; i < 16; i++) vecs.push_back('{1, 8'h00, 15 - i, 8'(i + 1), 1'b1});

    do_reset();

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_dout",  32'(data_out), 32'h00);
    repeat (3) pop_raw();
    chk("empty_pop_count", 32'(count), 32'd0);

    // Write latency: rise sampled at edge k, count visible after edge k+2
    data_rx      = 8'h2B;
    receive_done = 1'b1;
    tick();
    chk("lat_k",   32'(count), 32'd0);
    tick();
    chk("lat_k1",  32'(count), 32'd0);
    tick();
    chk("lat_k2",  32'(count), 32'd1);
    chk("lat_dout", 32'(data_out), 32'h2B);
    receive_done = 1'b0;
    repeat (3) tick();

    do_reset();
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.op == 0) begin
        push_raw(v.din, 1);
        repeat (20) tick();
      end else begin
        pop_raw();
      end
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(v.exp_count));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(v.exp_ov));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(v.exp_count == 0));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(v.exp_count == 16));
      if (v.exp_count > 0) chk($sformatf("vec%0d_head", i), 32'(data_out), 32'(v.exp_head));
    end

    // Long strobe produces exactly one write
    do_reset();
    data_rx      = 8'h41;
    receive_done = 1'b1;
    repeat (50) tick();
    chk("hold_count", 32'(count), 32'd1);
    receive_done = 1'b0;
    repeat (3) tick();
    chk("hold_count2", 32'(count), 32'd1);
    chk("hold_dout", 32'(data_out), 32'h41);

    // Simultaneous write and pop while full: wraps and keeps order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push_raw(8'(8'h10 + i), 1);
      m_push(8'(8'h10 + i));
    end
    chk_model("fill");
    push_pop_raw(8'hAA);
    m_push_pop(8'hAA);
    chk_model("full_pp");
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pop_raw();
      m_pop();
      chk_model($sformatf("drain%0d", i));
    end

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) push_raw(8'(8'h60 + i), 2);
    chk("pre_rst_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_ovf",   32'(overflow), 32'd0);
    chk("arst_valid", 32'(data_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    push_raw(8'h55, 1);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_dout",  32'(data_out), 32'h55);

    // Strobe already high when reset releases: one write three edges later
    rst_n        = 1'b0;
    data_rx      = 8'h77;
    receive_done = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_e1", 32'(count), 32'd0);
    tick();
    chk("rel_e2", 32'(count), 32'd0);
    tick();
    chk("rel_e3", 32'(count), 32'd1);
    chk("rel_dout", 32'(data_out), 32'h77);
    receive_done = 1'b0;
    repeat (3) tick();

    // Random traffic against the queue model
    do_reset();
    for (int it = 0; it < 300; it++) begin
      if (it == 150) do_reset();
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      if (r < 5) begin
        push_raw(b, $urandom_range(1, 6));
        m_push(b);
      end else if (r < 8) begin
        pop_raw();
        m_pop();
      end else begin
        push_pop_raw(b);
        m_push_pop(b);
      end
      chk_model($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_byte_buffer.md
Name: rx_byte_buffer

Overview:
- Receive-side byte FIFO between the UART receiver and the brainfuck core's `,` (input) path.
- Captures every byte the UART reports and holds it until the core explicitly requests it, so keystrokes arriving while the core is not executing `,` are no longer lost.
- Provides a show-ahead read port with a valid/request handshake, plus full/empty/occupancy and a sticky overflow flag.

Parameters:
- addrSize_fifo, 4, log2 of FIFO depth; depth = 2^addrSize_fifo bytes (default 16).

Ports:
- sysClk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- data_rx  input  8  received byte from UART; stable from its receive_done rise until the next frame completes.
- receive_done  input  1  UART byte-complete strobe; generated on uartClk, so treated as asynchronous to sysClk.
- rd_req  input  1  core pops the head byte this cycle; honoured only when data_valid=1.
- data_out  output  8  head byte; meaningful only while data_valid=1.
- data_valid  output  1  FIFO non-empty; equal to !empty.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == 2^addrSize_fifo.
- count  output  addrSize_fifo+1  current occupancy, 0..2^addrSize_fifo.
- overflow  output  1  sticky: a byte arrived while full and was dropped.

Behaviour:
- Reset (reset=0, async):
  - Read/write pointers, count and synchroniser flops go to 0; overflow=0.
  - Outputs: empty=1, full=0, data_valid=0, count=0, data_out=8'h00.
  - Storage array contents are don't-care.
- Strobe synchronisation:
  - receive_done passes through two flops (s1, s2), then a third flop (s2_d).
  - Write pulse wr = s2 & !s2_d: exactly one sysClk cycle per receive_done rising edge, regardless of strobe width.
  - A strobe held high across many cycles produces one write.
- Write timing and latency:
  - If s1 samples receive_done high at edge k, wr is high between edges k+1 and k+2.
  - data_rx is written at edge k+2.
  - data_valid/count update immediately after edge k+2: 3 sysClk edges of latency.
- Read:
  - Show-ahead: data_out = mem[rd_ptr] combinationally.
  - rd_req & data_valid at edge n advances rd_ptr; data_out shows the next byte after edge n.
  - rd_req while empty is ignored: no pointer or count change, no error.
- Pointers:
  - addrSize_fifo bits each, wrap naturally from 2^addrSize_fifo-1 to 0.
  - full/empty are derived from count, not pointer compare.
- Boundary conditions:
  - Write while full and no pop: byte dropped, pointers unchanged, overflow set to 1 and held until reset.
  - Write and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Write and rd_req in the same cycle while empty: rd_req ignored, write accepted, count becomes 1.
  - Write and pop in the same cycle otherwise: count unchanged, both pointers advance.
  - Reset mid-operation: all buffered bytes discarded; a receive_done already high at reset release produces one write after sync, i.e. 3 edges after release.
- No combinational path from rd_req to any output other than through registered state; data_out depends only on rd_ptr and array contents.

Decomposition:
- No shared package needed. Depth is derived locally as 1<<addrSize_fifo; no typedefs.
- One natural sub-module: pulse_sync (2-flop synchroniser + rising-edge detector, 1-bit in, 1-cycle pulse out, same sysClk/reset), reusable for other uartClk-domain strobes.
- FIFO storage is an inferred register array inside rx_byte_buffer. ramDualAccess is not used because a show-ahead read is required.

Test Plan:
- Reset release, no activity -> empty=1, data_valid=0, count=0, overflow=0, full=0; rd_req pulses leave count=0.
- Three receive_done pulses carrying 8'h2B, 8'h2D, 8'h2E, spaced 20 cycles apart; receive_done rise sampled at edge k -> count becomes 1 after edge k+2. Then rd_req for three cycles -> data_out reads 8'h2B, 8'h2D, 8'h2E in order, then empty=1.
- receive_done held high for 50 cycles with data_rx=8'h41 -> exactly one write, count=1.
- Sixteen bytes 8'h00..8'h0F (default depth) -> full=1, count=16. A 17th byte 8'hFF -> dropped, overflow=1, count=16. Sixteen pops -> 8'h00..8'h0F in order, overflow still 1.
- With the FIFO full, write pulse and rd_req in the same cycle -> count stays 16, overflow stays 0, and the new byte is read last after 16 pops (checks pointer wrap).
- Mid-stream reset after 5 bytes buffered -> count=0, empty=1, overflow=0 immediately (asynchronously). Next byte 8'h55 -> data_out=8'h55, count=1.
